// File: rtl/shift_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : shift_seq_ctrl
//  Purpose  : Command sequencer for an 8-bit universal shift register:
//             load operand, step it cmd_amt times, hand back the result.
//  Option   : SHIFT_SEQ_CTRL_ABORT_EN adds abort / res_aborted.
//  Revision : 1.0 - initial release
// ============================================================================
module shift_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_dir,
    input  logic [1:0]       cmd_mode,
    input  logic [CNT_W-1:0] cmd_amt,
    input  logic [WIDTH-1:0] sh_q,
    output logic [1:0]       sh_s,
    output logic [WIDTH-1:0] sh_in,
    output logic             sh_ir,
    output logic             sh_il,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
`ifdef SHIFT_SEQ_CTRL_ABORT_EN
    input  logic             abort,
    output logic             res_aborted,
`endif
    output logic             done
);

    localparam logic [1:0] SH_HOLD  = 2'b00;
    localparam logic [1:0] SH_LOAD  = 2'b01;
    localparam logic [1:0] SH_LEFT  = 2'b10;
    localparam logic [1:0] SH_RIGHT = 2'b11;

    localparam logic [1:0] MODE_FILL0 = 2'b00;
    localparam logic [1:0] MODE_FILL1 = 2'b01;
    localparam logic [1:0] MODE_ROT   = 2'b10;
    localparam logic [1:0] MODE_ARITH = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   data_r;
    logic               dir_r;
    logic [1:0]         mode_r;
    logic [CNT_W-1:0]   amt_r;
    logic [CNT_W-1:0]   cnt;
    logic               cmd_take;
`ifdef SHIFT_SEQ_CTRL_ABORT_EN
    logic               abort_take;
`endif

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign res_valid = (state == ST_DONE);
    assign res_data  = sh_q;
    assign cmd_take  = cmd_valid && cmd_ready;

    // State register, command capture, step counter and entry pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            data_r <= '0;
            dir_r  <= 1'b0;
            mode_r <= 2'b00;
            amt_r  <= '0;
            cnt    <= '0;
            done   <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= (state_nxt == ST_DONE) && (state != ST_DONE);
            if (cmd_take) begin
                data_r <= cmd_data;
                dir_r  <= cmd_dir;
                mode_r <= cmd_mode;
                amt_r  <= cmd_amt;
            end
            case (state)
                ST_LOAD:  cnt <= amt_r;
                ST_SHIFT: cnt <= cnt - CNT_W'(1);
                default:  cnt <= cnt;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        sh_s      = SH_HOLD;
        sh_in     = '0;
`ifdef SHIFT_SEQ_CTRL_ABORT_EN
        abort_take = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (cmd_take) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                sh_s      = SH_LOAD;
                sh_in     = data_r;
                state_nxt = (amt_r == '0) ? ST_DONE : ST_SHIFT;
            end
            ST_SHIFT: begin
                sh_s = dir_r ? SH_RIGHT : SH_LEFT;
                // Counter holds the steps still owed including this one
                if (cnt == CNT_W'(1)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
`ifdef SHIFT_SEQ_CTRL_ABORT_EN
        // Abort freezes the shifter this cycle so the partial value is returned
        if (abort && ((state == ST_LOAD) || (state == ST_SHIFT))) begin
            abort_take = 1'b1;
            sh_s       = SH_HOLD;
            state_nxt  = ST_DONE;
        end
`endif
    end

    always_comb begin
        sh_ir = 1'b0;
        sh_il = 1'b0;
        case (mode_r)
            MODE_FILL0: begin
                sh_ir = 1'b0;
                sh_il = 1'b0;
            end
            MODE_FILL1: begin
                sh_ir = 1'b1;
                sh_il = 1'b1;
            end
            MODE_ROT: begin
                sh_ir = sh_q[WIDTH-1];
                sh_il = sh_q[0];
            end
            MODE_ARITH: begin
                sh_ir = 1'b0;
                sh_il = sh_q[WIDTH-1];
            end
            default: begin
                sh_ir = 1'b0;
                sh_il = 1'b0;
            end
        endcase
    end

`ifdef SHIFT_SEQ_CTRL_ABORT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_aborted <= 1'b0;
        end else if (abort_take) begin
            res_aborted <= 1'b1;
        end else if (res_valid && res_ready) begin
            res_aborted <= 1'b0;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_shift_seq_ctrl.sv
`default_nettype none
// Testbench for shift_seq_ctrl: behavioural shifter, random commands,
// queue-based scoreboard checked by an independent monitor.
module tb_shift_seq_ctrl;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_data;
    logic             cmd_dir;
    logic [1:0]       cmd_mode;
    logic [CNT_W-1:0] cmd_amt;
    logic [WIDTH-1:0] sh_q;
    logic [1:0]       sh_s;
    logic [WIDTH-1:0] sh_in;
    logic             sh_ir;
    logic             sh_il;
    logic             busy;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             done;
`ifdef SHIFT_SEQ_CTRL_ABORT_EN
    logic             abort;
    logic             res_aborted;
`endif

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        logic [7:0] d;
        logic       dir;
        logic [1:0] mode;
        int         amt;
        logic [7:0] res;
        logic       aborted;
    } item_t;

    item_t exp_q[$];

    shift_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_data  (cmd_data),
        .cmd_dir   (cmd_dir),
        .cmd_mode  (cmd_mode),
        .cmd_amt   (cmd_amt),
        .sh_q      (sh_q),
        .sh_s      (sh_s),
        .sh_in     (sh_in),
        .sh_ir     (sh_ir),
        .sh_il     (sh_il),
        .busy      (busy),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
`ifdef SHIFT_SEQ_CTRL_ABORT_EN
        .abort       (abort),
        .res_aborted (res_aborted),
`endif
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Universal shift register sharing the controller's reset
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_q <= '0;
        end else begin
            case (sh_s)
                2'b01:   sh_q <= sh_in;
                2'b10:   sh_q <= {sh_q[WIDTH-2:0], sh_ir};
                2'b11:   sh_q <= {sh_il, sh_q[WIDTH-1:1]};
                default: sh_q <= sh_q;
            endcase
        end
    end

    // Whole-operation result computed arithmetically from the command
    function automatic logic [7:0] ref_result(input logic [7:0] d, input logic dir,
                                              input logic [1:0] mode, input int n);
        int v;
        int r;
        int s;
        int res;
        v = int'(d);
        r = n % 8;
        res = 0;
        if (!dir) begin
            case (mode)
                2'b01:   res = (v << n) | ((1 << n) - 1);
                2'b10:   res = (v << r) | (v >> (8 - r));
                default: res = v << n;
            endcase
        end else begin
            case (mode)
                2'b00:   res = v >> n;
                2'b01:   res = (v >> n) | (~(255 >> n));
                2'b10:   res = (v >> r) | (v << (8 - r));
                default: begin
                    s = (v >= 128) ? v - 256 : v;
                    res = s >>> n;
                end
            endcase
        end
        return res[7:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_vals();
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_sh_s", sh_s, 0);
        check("rst_sh_in", sh_in, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_done", done, 0);
        check("rst_sh_q", sh_q, 0);
`ifdef SHIFT_SEQ_CTRL_ABORT_EN
        check("rst_res_aborted", res_aborted, 0);
`endif
    endtask

    task automatic push_exp(input logic [7:0] d, input logic dir, input logic [1:0] mode, input int amt);
        item_t it;
        it.d = d;
        it.dir = dir;
        it.mode = mode;
        it.amt = amt;
        it.res = ref_result(d, dir, mode, amt);
        it.aborted = 1'b0;
        exp_q.push_back(it);
    endtask

    // Called just after a falling edge; returns one falling edge after acceptance
    task automatic send(input logic [7:0] d, input logic dir, input logic [1:0] mode, input int amt);
        int n;
        cmd_valid = 1'b1;
        cmd_data  = d;
        cmd_dir   = dir;
        cmd_mode  = mode;
        cmd_amt   = CNT_W'(amt);
        n = 0;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            errors++;
            checks++;
            $display("FAIL send_timeout: got cmd_ready=0 expected 1 within 200 cycles");
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic collect(input int wait_n);
        int n;
        n = 0;
        while (!res_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            errors++;
            checks++;
            $display("FAIL result_timeout: got res_valid=0 expected 1 within 200 cycles");
        end
        repeat (wait_n) @(negedge clk);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic run(input logic [7:0] d, input logic dir, input logic [1:0] mode,
                       input int amt, input int wait_n);
        push_exp(d, dir, mode, amt);
        send(d, dir, mode, amt);
        collect(wait_n);
    endtask

    // Monitor: samples shortly after each falling edge
    initial begin
        int         accept_cyc;
        bit         in_txn;
        bit         prev_valid;
        logic [7:0] held;
        logic [1:0] seq[$];
        logic [1:0] eseq[$];
        item_t      it;
        accept_cyc = 0;
        in_txn = 0;
        prev_valid = 0;
        held = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!reset) begin
                in_txn = 0;
                prev_valid = 0;
                continue;
            end
            if (cmd_valid && cmd_ready) begin
                accept_cyc = cyc;
                in_txn = 1;
                seq.delete();
            end else if (in_txn && !prev_valid) begin
                seq.push_back(sh_s);
            end
            if (res_valid) begin
                if (!prev_valid) begin
                    held = res_data;
                    check("done_entry", done, 1);
                    if (exp_q.size() > 0 && !exp_q[0].aborted)
                        check("latency", cyc - accept_cyc, exp_q[0].amt + 2);
                end else begin
                    check("res_stable", res_data, held);
                    check("done_single", done, 0);
                end
                check("cmd_ready_in_done", cmd_ready, 0);
                if (res_ready) begin
                    if (exp_q.size() == 0) begin
                        errors++;
                        checks++;
                        $display("FAIL unexpected_result: got %0h expected none", res_data);
                    end else begin
                        it = exp_q.pop_front();
                        check("res_data", res_data, it.res);
`ifdef SHIFT_SEQ_CTRL_ABORT_EN
                        check("res_aborted", res_aborted, it.aborted);
`endif
                        if (!it.aborted && in_txn) begin
                            eseq.delete();
                            eseq.push_back(2'b01);
                            for (int i = 0; i < it.amt; i++)
                                eseq.push_back(it.dir ? 2'b11 : 2'b10);
                            eseq.push_back(2'b00);
                            check("sh_s_seq_len", seq.size(), eseq.size());
                            if (seq.size() == eseq.size())
                                for (int i = 0; i < eseq.size(); i++)
                                    check("sh_s_seq", seq[i], eseq[i]);
                        end
                    end
                    in_txn = 0;
                end
            end
            prev_valid = res_valid;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish by 2ms");
        $fatal(1, "watchdog");
    end

    initial begin
        cmd_valid = 1'b0;
        cmd_data  = '0;
        cmd_dir   = 1'b0;
        cmd_mode  = 2'b00;
        cmd_amt   = '0;
        res_ready = 1'b0;
`ifdef SHIFT_SEQ_CTRL_ABORT_EN
        abort = 1'b0;
`endif
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_reset_vals();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        run(8'hA5, 1'b0, 2'b00, 3, 0);
        run(8'h96, 1'b1, 2'b11, 2, 1);
        run(8'h81, 1'b1, 2'b10, 1, 0);
        run(8'h81, 1'b0, 2'b10, 9, 2);
        run(8'h00, 1'b0, 2'b01, 4, 0);
        run(8'h3C, 1'b0, 2'b00, 0, 0);
        run(8'h80, 1'b1, 2'b11, 15, 0);
        run(8'h5A, 1'b1, 2'b01, 12, 1);

        // Backpressure with a second command waiting during DONE
        push_exp(8'h5A, 1'b1, 2'b00, 5);
        send(8'h5A, 1'b1, 2'b00, 5);
        while (!res_valid) @(negedge clk);
        push_exp(8'hC3, 1'b0, 2'b10, 3);
        cmd_valid = 1'b1;
        cmd_data  = 8'hC3;
        cmd_dir   = 1'b0;
        cmd_mode  = 2'b10;
        cmd_amt   = 4'd3;
        repeat (4) @(negedge clk);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        #1;
        check("ready_after_accept", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        collect(0);

        // Reset in the middle of SHIFT after two steps
        send(8'h77, 1'b0, 2'b00, 6);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_vals();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run(8'h12, 1'b0, 2'b01, 2, 0);

`ifdef SHIFT_SEQ_CTRL_ABORT_EN
        begin
            item_t ab;
            ab.d = 8'h01;
            ab.dir = 1'b0;
            ab.mode = 2'b00;
            ab.amt = 6;
            ab.res = 8'h04;
            ab.aborted = 1'b1;
            exp_q.push_back(ab);
            send(8'h01, 1'b0, 2'b00, 6);
            repeat (3) @(negedge clk);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            collect(1);
            #1;
            check("aborted_cleared", res_aborted, 0);
        end
`endif

        for (int k = 0; k < 40; k++) begin
            run(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                2'($urandom_range(0, 3)), $urandom_range(0, 15), $urandom_range(0, 3));
        end

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
